// File: rtl/axis_fifo_reader.sv
// Drains a standard-mode native FIFO read port into an AXI-Stream master through a small skid buffer.
// Optional: define AXIS_FIFO_READER_FRAME_COUNT_EN to add the m_frame_count port and counter.
module axis_fifo_reader #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_HAS_KEEP     = 0,
  parameter int C_HAS_LAST     = 1,
  parameter int C_READ_LATENCY = 1,
  localparam int C_KEEP_WIDTH  = C_DATA_WIDTH / 8,
  localparam int C_FIFO_WIDTH  = C_DATA_WIDTH + ((C_HAS_KEEP != 0) ? C_KEEP_WIDTH : 0)
                                 + ((C_HAS_LAST != 0) ? 1 : 0)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    f_empty,
  output logic                    f_rd_en,
  input  logic [C_FIFO_WIDTH-1:0] f_dout,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
`ifdef AXIS_FIFO_READER_FRAME_COUNT_EN
  ,
  output logic [31:0]             m_frame_count
`endif
);

  localparam int DEPTH = C_READ_LATENCY + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [C_READ_LATENCY-1:0] rd_pipe;
  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;
  logic [OCC_W-1:0]          occupancy;
  logic [OCC_W-1:0]          inflight;
  logic [C_DATA_WIDTH-1:0]   data_mem [DEPTH];
  logic [C_KEEP_WIDTH-1:0]   keep_mem [DEPTH];
  logic                      last_mem [DEPTH];

  logic                    pop;
  logic                    capture;
  logic [C_DATA_WIDTH-1:0] word_data;
  logic [C_KEEP_WIDTH-1:0] word_keep;
  logic                    word_last;

  assign word_data = f_dout[C_DATA_WIDTH-1:0];

  generate
    if (C_HAS_KEEP != 0) begin : g_keep
      assign word_keep = f_dout[C_DATA_WIDTH +: C_KEEP_WIDTH];
    end else begin : g_no_keep
      assign word_keep = '1;
    end
    if (C_HAS_LAST != 0) begin : g_last
      assign word_last = f_dout[C_FIFO_WIDTH-1];
    end else begin : g_no_last
      assign word_last = 1'b1;
    end
  endgenerate

  assign capture       = rd_pipe[C_READ_LATENCY-1];
  assign m_axis_tvalid = (occupancy != '0);
  assign pop           = m_axis_tvalid & m_axis_tready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < C_READ_LATENCY; i++) begin
      inflight = inflight + OCC_W'(rd_pipe[i]);
    end
  end

  // Only pop upstream when the buffer is guaranteed a free slot for the word when it lands.
  assign f_rd_en = ~f_empty &
                   ((int'(occupancy) + int'(inflight) - int'(pop)) < DEPTH);

  assign m_axis_tdata = data_mem[head];
  assign m_axis_tkeep = keep_mem[head];
  assign m_axis_tlast = (C_HAS_LAST != 0) ? last_mem[head] : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe   <= '0;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        keep_mem[i] <= '1;
        last_mem[i] <= 1'b0;
      end
    end else begin
      rd_pipe <= (rd_pipe << 1) | C_READ_LATENCY'(f_rd_en);
      if (capture) begin
        data_mem[tail] <= word_data;
        keep_mem[tail] <= word_keep;
        last_mem[tail] <= word_last;
        tail <= (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;
      end
      if (pop) begin
        head <= (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
      end
      case ({capture, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef AXIS_FIFO_READER_FRAME_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_frame_count <= '0;
    end else if (pop && m_axis_tlast) begin
      m_frame_count <= m_frame_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_fifo_reader.sv
// Scoreboard bench for axis_fifo_reader: instance a (latency 1, keep+last), instance b (latency 2, bare data).
module tb_axis_fifo_reader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t       exp_a[$];
  beat_t       exp_b[$];
  logic [36:0] fifo_a[$];
  logic [31:0] fifo_b[$];

  logic        f_empty_a, f_rd_en_a, tlast_a, tvalid_a;
  logic        tready_a = 1'b0;
  logic [36:0] f_dout_a;
  logic [31:0] tdata_a;
  logic [3:0]  tkeep_a;

  logic        f_empty_b, f_rd_en_b, tlast_b, tvalid_b;
  logic        tready_b = 1'b0;
  logic [31:0] f_dout_b, s1_b;
  logic [31:0] tdata_b;
  logic [3:0]  tkeep_b;

`ifdef AXIS_FIFO_READER_FRAME_COUNT_EN
  logic [31:0] fcount_a, fcount_b;
`endif

  axis_fifo_reader #(.C_DATA_WIDTH(32), .C_HAS_KEEP(1), .C_HAS_LAST(1), .C_READ_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .f_empty(f_empty_a), .f_rd_en(f_rd_en_a), .f_dout(f_dout_a),
    .m_axis_tdata(tdata_a), .m_axis_tkeep(tkeep_a), .m_axis_tlast(tlast_a),
    .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a)
`ifdef AXIS_FIFO_READER_FRAME_COUNT_EN
    , .m_frame_count(fcount_a)
`endif
  );

  axis_fifo_reader #(.C_DATA_WIDTH(32), .C_HAS_KEEP(0), .C_HAS_LAST(0), .C_READ_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .f_empty(f_empty_b), .f_rd_en(f_rd_en_b), .f_dout(f_dout_b),
    .m_axis_tdata(tdata_b), .m_axis_tkeep(tkeep_b), .m_axis_tlast(tlast_b),
    .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b)
`ifdef AXIS_FIFO_READER_FRAME_COUNT_EN
    , .m_frame_count(fcount_b)
`endif
  );

  // Upstream FIFO models: registered empty flag, one or two cycles of read latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_a.delete();
      f_empty_a <= 1'b1;
      f_dout_a  <= '0;
    end else begin
      if (f_rd_en_a) f_dout_a <= fifo_a.pop_front();
      f_empty_a <= (fifo_a.size() == 0);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_b.delete();
      f_empty_b <= 1'b1;
      s1_b      <= '0;
      f_dout_b  <= '0;
    end else begin
      if (f_rd_en_b) s1_b <= fifo_b.pop_front();
      f_dout_b  <= s1_b;
      f_empty_b <= (fifo_b.size() == 0);
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int   rd_cnt_a = 0, beats_a = 0, first_rd_a = -1, first_beat_a = -1, last_beat_a = 0, max_out_a = 0;
  int   rd_cnt_b = 0, beats_b = 0, max_out_b = 0, tot_beats_b = 0;
  logic hold_a = 1'b0, hold_b = 1'b0;
  logic [36:0] held_a, held_b;

  // Monitors: pop the scoreboard on every handshake and enforce AXIS hold rules.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      hold_a = 1'b0;
    end else begin
      if (f_rd_en_a) begin
        rd_cnt_a++;
        if (first_rd_a < 0) first_rd_a = cyc;
      end
      if (hold_a) begin
        check_output("a_tvalid_held", 64'(tvalid_a), 64'd1);
        check_output("a_beat_stable", 64'({tlast_a, tkeep_a, tdata_a}), 64'(held_a));
      end
      if (tvalid_a && tready_a) begin
        if (exp_a.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL a_extra_beat: got 0x%0h, expected no beat", tdata_a);
        end else begin
          e = exp_a.pop_front();
          check_output("a_beat", 64'({tlast_a, tkeep_a, tdata_a}), 64'({e.last, e.keep, e.data}));
        end
        beats_a++;
        if (first_beat_a < 0) first_beat_a = cyc;
        last_beat_a = cyc;
      end
      if (rd_cnt_a - beats_a > max_out_a) max_out_a = rd_cnt_a - beats_a;
      hold_a = tvalid_a && !tready_a;
      held_a = {tlast_a, tkeep_a, tdata_a};
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      hold_b = 1'b0;
      tot_beats_b = 0;
    end else begin
      if (f_rd_en_b) rd_cnt_b++;
      if (hold_b) begin
        check_output("b_tvalid_held", 64'(tvalid_b), 64'd1);
        check_output("b_beat_stable", 64'({tlast_b, tkeep_b, tdata_b}), 64'(held_b));
      end
      if (tvalid_b && tready_b) begin
        if (exp_b.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL b_extra_beat: got 0x%0h, expected no beat", tdata_b);
        end else begin
          e = exp_b.pop_front();
          check_output("b_beat", 64'({tlast_b, tkeep_b, tdata_b}), 64'({e.last, e.keep, e.data}));
        end
        beats_b++;
        tot_beats_b++;
      end
      if (rd_cnt_b - beats_b > max_out_b) max_out_b = rd_cnt_b - beats_b;
      hold_b = tvalid_b && !tready_b;
      held_b = {tlast_b, tkeep_b, tdata_b};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_a(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t e;
    e = '{d, k, l};
    fifo_a.push_back({l, k, d});
    exp_a.push_back(e);
  endtask

  task automatic apply_stimulus_b(input logic [31:0] d);
    beat_t e;
    e = '{d, 4'hF, 1'b1};
    fifo_b.push_back(d);
    exp_b.push_back(e);
  endtask

  task automatic clear_counters();
    rd_cnt_a = 0; beats_a = 0; first_rd_a = -1; first_beat_a = -1; max_out_a = 0;
    rd_cnt_b = 0; beats_b = 0; max_out_b = 0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && (exp_a.size() != 0 || exp_b.size() != 0); i++) tick(1);
    check_output(name, 64'(exp_a.size() + exp_b.size()), 64'd0);
    tick(4);
  endtask

  task automatic check_reset_values();
    check_output("rst_rd_en_a", 64'(f_rd_en_a), 64'd0);
    check_output("rst_tvalid_a", 64'(tvalid_a), 64'd0);
    check_output("rst_tdata_a", 64'(tdata_a), 64'd0);
    check_output("rst_tkeep_a", 64'(tkeep_a), 64'hF);
    check_output("rst_tlast_a", 64'(tlast_a), 64'd0);
    check_output("rst_tvalid_b", 64'(tvalid_b), 64'd0);
    check_output("rst_tkeep_b", 64'(tkeep_b), 64'hF);
    check_output("rst_tlast_b", 64'(tlast_b), 64'd1);
`ifdef AXIS_FIFO_READER_FRAME_COUNT_EN
    check_output("rst_fcount_a", 64'(fcount_a), 64'd0);
    check_output("rst_fcount_b", 64'(fcount_b), 64'd0);
`endif
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 check_reset_values();
    tick(3);
    rst = 1'b0;
    tick(2);

    // Continuous stream on the latency-1 instance.
    clear_counters();
    tready_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] k;
      k = 4'hF >> (i % 4);
      apply_stimulus_a(32'(i), k, (i == 7));
    end
    wait_drain("cont_drain");
    check_output("cont_beats", 64'(beats_a), 64'd8);
    check_output("cont_latency", 64'(first_beat_a - first_rd_a), 64'd2);
    check_output("cont_back_to_back", 64'(last_beat_a - first_beat_a), 64'd7);
    check_output("cont_outstanding_ok", 64'(max_out_a <= 2), 64'd1);
`ifdef AXIS_FIFO_READER_FRAME_COUNT_EN
    check_output("cont_fcount", 64'(fcount_a), 64'd1);
`endif

    // Toggled backpressure on the latency-2 instance.
    clear_counters();
    tready_b = 1'b0;
    for (int i = 0; i < 16; i++) apply_stimulus_b(32'h100 + 32'(i));
    for (int i = 0; i < 400 && exp_b.size() != 0; i++) begin
      tready_b = ~tready_b;
      tick(1);
    end
    check_output("bp_drain", 64'(exp_b.size()), 64'd0);
    tready_b = 1'b1;
    tick(4);
    check_output("bp_beats", 64'(beats_b), 64'd16);
    check_output("bp_outstanding_ok", 64'(max_out_b <= 3), 64'd1);

    // Sink stalled with a full FIFO.
    clear_counters();
    tready_a = 1'b0;
    for (int i = 0; i < 6; i++) apply_stimulus_a(32'h200 + 32'(i), 4'hF, (i == 5));
    tick(20);
    check_output("stall_rd_pulses", 64'(rd_cnt_a), 64'd2);
    check_output("stall_tvalid", 64'(tvalid_a), 64'd1);
    check_output("stall_tdata", 64'(tdata_a), 64'h200);
    tready_a = 1'b1;
    wait_drain("stall_drain");
    check_output("stall_beats", 64'(beats_a), 64'd6);
`ifdef AXIS_FIFO_READER_FRAME_COUNT_EN
    check_output("stall_fcount", 64'(fcount_a), 64'd2);
`endif

    // Single word, FIFO empties while it is in flight.
    clear_counters();
    tready_b = 1'b1;
    apply_stimulus_b(32'h300);
    tick(10);
    check_output("single_beats", 64'(beats_b), 64'd1);
    check_output("single_rd_pulses", 64'(rd_cnt_b), 64'd1);
    check_output("single_tvalid", 64'(tvalid_b), 64'd0);
    check_output("single_rd_en", 64'(f_rd_en_b), 64'd0);
    check_output("single_tlast_b", 64'(tlast_b), 64'd1);
`ifdef AXIS_FIFO_READER_FRAME_COUNT_EN
    check_output("bare_fcount_b", 64'(fcount_b), 64'(tot_beats_b));
`endif

    // Reset with two words sitting in the buffer.
    clear_counters();
    tready_a = 1'b0;
    apply_stimulus_a(32'h400, 4'h3, 1'b0);
    apply_stimulus_a(32'h401, 4'h7, 1'b0);
    tick(6);
    check_output("prerst_tvalid", 64'(tvalid_a), 64'd1);
    check_output("prerst_tdata", 64'(tdata_a), 64'h400);
    #2 rst = 1'b1;
    #1 check_output("rst_async_tvalid", 64'(tvalid_a), 64'd0);
    exp_a.delete();
    exp_b.delete();
    tick(2);
    check_reset_values();
    rst = 1'b0;
    clear_counters();
    tick(2);
    tready_a = 1'b1;
    apply_stimulus_a(32'hA5, 4'hF, 1'b1);
    wait_drain("rst_refill_drain");
    check_output("rst_refill_beats", 64'(beats_a), 64'd1);
`ifdef AXIS_FIFO_READER_FRAME_COUNT_EN
    check_output("rst_refill_fcount", 64'(fcount_a), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
